// File: rtl/rob_flush.sv
`default_nettype none
// ============================================================================
// Module : rob_flush
// Reorder buffer: in-order allocate/commit, CDB completion, mispredict flush.
// Optional macro ROB_ORDER_EN adds per-slot retired-instruction ordinals.
// Rev    : 1.0
// ============================================================================
module rob_flush #(
    parameter int DEPTH          = 32,
    parameter int DISPATCH_WIDTH = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int CDB_WIDTH      = 2,
    parameter int PRF_IDX        = 6,
    localparam int ROB_IDX       = $clog2(DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                disp_valid,
    output logic                                disp_ready,
    input  logic [DISPATCH_WIDTH-1:0]           disp_inst_valid,
    input  logic [DISPATCH_WIDTH*PRF_IDX-1:0]   disp_rd_phy,
    input  logic [DISPATCH_WIDTH*5-1:0]         disp_rd_arch,
    output logic [DISPATCH_WIDTH*ROB_IDX-1:0]   disp_rob_id,
    input  logic [CDB_WIDTH-1:0]                cdb_valid,
    input  logic [CDB_WIDTH*ROB_IDX-1:0]        cdb_rob_id,
    input  logic [CDB_WIDTH-1:0]                cdb_mispredict,
    output logic [COMMIT_WIDTH-1:0]             commit_valid,
    output logic [COMMIT_WIDTH*PRF_IDX-1:0]     commit_rd_phy,
    output logic [COMMIT_WIDTH*5-1:0]           commit_rd_arch,
`ifdef ROB_ORDER_EN
    output logic [COMMIT_WIDTH*64-1:0]          commit_order,
`endif
    output logic                                flush,
    output logic [ROB_IDX:0]                    count
);

    localparam int c_PTR_W = ROB_IDX + 1;
    localparam logic [c_PTR_W:0] c_DEPTH_E = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W:0] c_DW_E    = (c_PTR_W+1)'(DISPATCH_WIDTH);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_PTR_W-1:0]     r_head;
    logic [c_PTR_W-1:0]     r_tail;
    logic [DEPTH-1:0]       r_valid;
    logic [DEPTH-1:0]       r_done;
    logic [DEPTH-1:0]       r_mis;
    logic [PRF_IDX-1:0]     r_rd_phy  [DEPTH];
    logic [4:0]             r_rd_arch [DEPTH];

    logic [c_PTR_W-1:0]     w_count;
    logic [c_PTR_W:0]       w_free;
    logic                   w_disp_fire;
    logic [c_PTR_W-1:0]     w_disp_n;
    logic [ROB_IDX-1:0]     w_disp_idx [DISPATCH_WIDTH];
    logic [ROB_IDX-1:0]     w_cmt_idx  [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] w_commit;
    logic [c_PTR_W-1:0]     w_ncommit;
    logic [c_PTR_W-1:0]     w_head_n;
    logic                   w_flush_go;
    logic                   w_cmt_run;
    logic [DEPTH-1:0]       w_valid_n;
    logic [DEPTH-1:0]       w_done_n;
    logic [DEPTH-1:0]       w_mis_n;

    assign w_count     = r_tail - r_head;
    assign count       = w_count;
    assign w_free      = c_DEPTH_E - {1'b0, w_count};
    assign disp_ready  = (r_state == S_RUN) && (w_free >= c_DW_E);
    assign w_disp_fire = disp_valid && disp_ready;
    assign flush       = (r_state == S_FLUSH);

    // Valid slots are compacted onto consecutive entries starting at tail.
    always_comb begin
        w_disp_n = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            w_disp_idx[i] = r_tail[ROB_IDX-1:0] + w_disp_n[ROB_IDX-1:0];
            if (disp_inst_valid[i]) begin
                w_disp_n = w_disp_n + 1'b1;
            end
        end
    end

    // Commit is an unbroken prefix from head; a mispredicted entry ends it.
    always_comb begin
        w_commit   = '0;
        w_ncommit  = '0;
        w_flush_go = 1'b0;
        w_cmt_run  = (r_state == S_RUN);
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            w_cmt_idx[k] = r_head[ROB_IDX-1:0] + ROB_IDX'(k);
            if (w_cmt_run && (c_PTR_W'(k) < w_count) &&
                r_valid[w_cmt_idx[k]] && r_done[w_cmt_idx[k]]) begin
                w_commit[k] = 1'b1;
                w_ncommit   = w_ncommit + 1'b1;
                if (r_mis[w_cmt_idx[k]]) begin
                    w_flush_go = 1'b1;
                    w_cmt_run  = 1'b0;
                end
            end else begin
                w_cmt_run = 1'b0;
            end
        end
    end

    assign w_head_n = r_head + w_ncommit;

    always_comb begin
        w_valid_n = r_valid;
        w_done_n  = r_done;
        w_mis_n   = r_mis;
        if ((r_state == S_FLUSH) || w_flush_go) begin
            w_valid_n = '0;
            w_done_n  = '0;
            w_mis_n   = '0;
        end else begin
            for (int p = 0; p < CDB_WIDTH; p++) begin
                if (cdb_valid[p] && r_valid[cdb_rob_id[p*ROB_IDX +: ROB_IDX]]) begin
                    w_done_n[cdb_rob_id[p*ROB_IDX +: ROB_IDX]] = 1'b1;
                    w_mis_n[cdb_rob_id[p*ROB_IDX +: ROB_IDX]]  =
                        w_mis_n[cdb_rob_id[p*ROB_IDX +: ROB_IDX]] | cdb_mispredict[p];
                end
            end
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (w_commit[k]) begin
                    w_valid_n[w_cmt_idx[k]] = 1'b0;
                    w_done_n[w_cmt_idx[k]]  = 1'b0;
                    w_mis_n[w_cmt_idx[k]]   = 1'b0;
                end
            end
            if (w_disp_fire) begin
                for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                    if (disp_inst_valid[i]) begin
                        w_valid_n[w_disp_idx[i]] = 1'b1;
                        w_done_n[w_disp_idx[i]]  = 1'b0;
                        w_mis_n[w_disp_idx[i]]   = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_mis   <= '0;
        end else begin
            r_valid <= w_valid_n;
            r_done  <= w_done_n;
            r_mis   <= w_mis_n;
            if (r_state == S_FLUSH) begin
                r_state <= S_RUN;
                r_tail  <= r_head;
            end else begin
                r_head <= w_head_n;
                // Tail snaps to the post-commit head so count reads 0 during the flush pulse.
                if (w_flush_go) begin
                    r_state <= S_FLUSH;
                    r_tail  <= w_head_n;
                end else if (w_disp_fire) begin
                    r_tail <= r_tail + w_disp_n;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (w_disp_fire && disp_inst_valid[i]) begin
                r_rd_phy[w_disp_idx[i]]  <= disp_rd_phy[i*PRF_IDX +: PRF_IDX];
                r_rd_arch[w_disp_idx[i]] <= disp_rd_arch[i*5 +: 5];
            end
        end
    end

    assign commit_valid = w_commit;

`ifdef ROB_ORDER_EN
    logic [63:0] r_order;

    // Not rewound on flush: the mispredicted branch itself retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_order <= '0;
        end else begin
            r_order <= r_order + 64'(w_ncommit);
        end
    end
`endif

    for (genvar g = 0; g < COMMIT_WIDTH; g++) begin : g_commit
        assign commit_rd_phy[g*PRF_IDX +: PRF_IDX] = r_rd_phy[w_cmt_idx[g]];
        assign commit_rd_arch[g*5 +: 5]            = r_rd_arch[w_cmt_idx[g]];
`ifdef ROB_ORDER_EN
        assign commit_order[g*64 +: 64]            = r_order + 64'(g);
`endif
    end

    for (genvar g = 0; g < DISPATCH_WIDTH; g++) begin : g_disp_id
        assign disp_rob_id[g*ROB_IDX +: ROB_IDX] = w_disp_idx[g];
    end

endmodule
`default_nettype wire

// File: doc/rob_flush.md
Name: rob_flush

Overview:
- Parametrised reorder buffer (ROB) for the out-of-order backend.
- Allocates entries in program order from rename/dispatch and tracks completion from CDB broadcasts.
- Commits up to COMMIT_WIDTH oldest completed entries per cycle to the retirement RAT/free list.
- Recovers from a branch mispredict by committing the mispredicted branch, then asserting a one-cycle flush and discarding all younger entries.

Parameters:
- DEPTH, 32, number of entries (power of 2, >= 2*DISPATCH_WIDTH); ROB_IDX = log2(DEPTH).
- DISPATCH_WIDTH, 2, instruction slots offered per dispatch cycle.
- COMMIT_WIDTH, 2, maximum entries retired per cycle (<= DEPTH).
- CDB_WIDTH, 2, number of completion broadcast ports.
- PRF_IDX, 6, physical register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- disp_valid  in  1  dispatch group offered
- disp_ready  out  1  group accepted this cycle when disp_valid && disp_ready
- disp_inst_valid  in  DISPATCH_WIDTH  per-slot instruction present
- disp_rd_phy  in  DISPATCH_WIDTH*PRF_IDX  per-slot destination physical register
- disp_rd_arch  in  DISPATCH_WIDTH*5  per-slot destination architectural register
- disp_rob_id  out  DISPATCH_WIDTH*ROB_IDX  per-slot allocated index (combinational)
- cdb_valid  in  CDB_WIDTH  completion broadcast
- cdb_rob_id  in  CDB_WIDTH*ROB_IDX  completing entry
- cdb_mispredict  in  CDB_WIDTH  completing instruction was a mispredicted branch
- commit_valid  out  COMMIT_WIDTH  slot k retires this cycle
- commit_rd_phy  out  COMMIT_WIDTH*PRF_IDX  retiring physical register
- commit_rd_arch  out  COMMIT_WIDTH*5  retiring architectural register
- flush  out  1  one-cycle pipeline flush pulse
- count  out  ROB_IDX+1  occupied entries

Behaviour:
- Storage: flat circular buffer with head/tail pointers of ROB_IDX+1 bits (wrap flag in MSB).
  - Empty: pointers equal.
  - Full: index bits equal and flags differ.
  - count = tail - head, computed modulo 2^(ROB_IDX+1).
- Each entry holds: valid, done, mispredict, rd_phy, rd_arch.
- Reset:
  - head = tail = 0; all valid/done/mispredict bits = 0; state = RUN.
  - Outputs: commit_valid = 0, flush = 0, count = 0, disp_ready = 1.
  - rst takes priority over every other event, including mid-flush.
- Dispatch:
  - disp_ready = (state == RUN) && (DEPTH - count >= DISPATCH_WIDTH).
  - On accept, valid slots are compacted: slot i gets index tail + (number of valid slots below i).
  - Invalid slots consume no entry, and their disp_rob_id is don't-care.
  - The new entry is written with valid = 1, done = 0, mispredict = 0.
  - tail advances by popcount(disp_inst_valid). A group with zero valid slots is accepted with no change.
- Completion:
  - For each cdb port with cdb_valid, if the target entry is valid: set done = 1 and OR in mispredict.
  - Broadcasts to invalid entries are ignored.
  - Duplicate IDs on two ports in the same cycle: done is set, mispredict is the OR of both ports.
  - Completion in the same cycle as commit of that entry has no effect on that cycle's commit (registered done only).
- Commit (combinational from registered state):
  - Slot k is valid iff entries head..head+k are all valid && done, no earlier slot's entry has mispredict set, k < count, and state == RUN.
  - head advances by the number of committed slots; committed entries have valid cleared.
  - Head wrap across DEPTH-1 -> 0 is seamless.
- States RUN, FLUSH:
  - RUN -> FLUSH when a committing slot's entry has mispredict = 1. That entry commits; all younger slots are suppressed.
  - Any dispatch accepted in that same cycle is discarded by the flush.
  - In FLUSH: flush = 1 for exactly one cycle, every entry's valid/done/mispredict is cleared, tail = head, commit_valid = 0, disp_ready = 0, CDB ignored.
  - FLUSH -> RUN unconditionally on the next cycle.
- Full with head not done: no commit and no dispatch, so the ROB stalls.
- Simultaneous commit and dispatch on a full ROB: disp_ready uses the registered count, so dispatch is not accepted that cycle.

Optional Feature:
- Macro: ROB_ORDER_EN.
- When defined:
  - Adds output commit_order, width COMMIT_WIDTH*64.
  - commit_order slot k = a 64-bit retired-instruction counter + k.
  - The counter resets to 0 and advances by the number of committed slots each cycle.
  - The counter is not rewound on flush, because the mispredicted branch itself counts.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan (DEPTH=16, DISPATCH_WIDTH=2, COMMIT_WIDTH=2):
- Reset, then dispatch 8 groups of 2 valid slots -> disp_rob_id 0..15 in order; count=16; disp_ready=0 after the 8th group.
- Dispatch slots {0 invalid, 1 valid} then {1,1} -> IDs 0, 1, 2 assigned; count=3.
- Complete IDs 1 then 0 in separate cycles -> no commit after ID 1; after ID 0 completes, commit_valid=2'b11 (rd of 0, 1) on the following cycle; head=2.
- Entries 0..3 allocated; CDB marks 0 done+mispredict and 1 done -> commit_valid=2'b01 for entry 0; next cycle flush=1 and count=0; cycle after, disp_ready=1 and next disp_rob_id=1.
- Fill to 14 entries with head at index 10, then dispatch 2 -> IDs 8 and 9 (tail wraps past 15); commit wraps head 15 -> 0 without gap.
- ROB_ORDER_EN defined: 5 commits split 2+2+1 -> commit_order values 0, 1, 2, 3, 4.
